// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between the entry decoder, the sequencer and the display.
// The master side drives requests and result acceptance; the slave side is the sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
);
    logic [2*WIDTH+OPW-1:0] nr_coded;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       result;
    logic [WIDTH-1:0]       remainder;
    logic                   flag_c;
    logic                   err;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        output nr_coded, in_valid, out_ready,
        input  in_ready, result, remainder, flag_c, err, out_valid, busy
    );

    modport slave (
        input  nr_coded, in_valid, out_ready,
        output in_ready, result, remainder, flag_c, err, out_valid, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencing controller for the calculator ALU: accepts one {op,b,a} request, runs
// single-cycle add/sub/clr or WIDTH-cycle shift-add mul / restoring div, returns the result.
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_CLR = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB = OPW'(2);
    localparam logic [OPW-1:0] OP_MUL = OPW'(3);
    localparam logic [OPW-1:0] OP_DIV = OPW'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [OPW-1:0]     r_op;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_bsh;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_flag_c;
    logic               r_err;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [OPW-1:0]     w_op;
    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_last;
    logic               w_iter;

    assign w_a  = bus.nr_coded[WIDTH-1:0];
    assign w_b  = bus.nr_coded[2*WIDTH-1:WIDTH];
    assign w_op = bus.nr_coded[2*WIDTH+OPW-1:2*WIDTH];

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

    assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_diff = r_opa - r_opb;

    // Multiplier bits are consumed LSB first from r_opa while b<<i walks up in r_bsh.
    assign w_mul_nxt = r_opa[0] ? (r_acc + r_bsh) : r_acc;

    // Dividend bits are consumed MSB first from r_opa; the partial remainder always fits WIDTH bits.
    assign w_trial   = {r_rem, r_opa[WIDTH-1]};
    assign w_ge      = (w_trial >= {1'b0, r_opb});
    assign w_rem_nxt = w_ge ? (w_trial[WIDTH-1:0] - r_opb) : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    assign w_last = (r_cnt == CW'(WIDTH - 1));
    assign w_iter = (r_op == OP_MUL) || ((r_op == OP_DIV) && (r_opb != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!w_iter || w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_bsh       <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_remainder <= '0;
            r_flag_c    <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_op     <= w_op;
            r_opa    <= w_a;
            r_opb    <= w_b;
            r_bsh    <= {{WIDTH{1'b0}}, w_b};
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_flag_c <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            case (r_op)
                OP_CLR: begin
                    r_result    <= '0;
                    r_remainder <= '0;
                    r_flag_c    <= 1'b0;
                    r_err       <= 1'b0;
                end
                OP_ADD: begin
                    r_result    <= w_sum[WIDTH-1:0];
                    r_remainder <= '0;
                    r_flag_c    <= w_sum[WIDTH];
                end
                OP_SUB: begin
                    r_result    <= w_diff;
                    r_remainder <= '0;
                    r_flag_c    <= (r_opa < r_opb);
                end
                OP_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_bsh <= {r_bsh[2*WIDTH-2:0], 1'b0};
                    r_opa <= {1'b0, r_opa[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result    <= w_mul_nxt[WIDTH-1:0];
                        r_remainder <= '0;
                        r_flag_c    <= |w_mul_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                OP_DIV: begin
                    if (r_opb == '0) begin
                        r_result    <= '1;
                        r_remainder <= r_opa;
                        r_err       <= 1'b1;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_opa <= {r_opa[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_result    <= w_quo_nxt;
                            r_remainder <= w_rem_nxt;
                        end
                    end
                end
                default: begin
                    r_result    <= '0;
                    r_remainder <= '0;
                    r_err       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.result    = r_result;
    assign bus.remainder = r_remainder;
    assign bus.flag_c    = r_flag_c;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expectations are queued at request time
// from a behavioural arithmetic model and compared when the result handshake appears.
module tb_alu_op_sequencer;
    localparam int W   = 4;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(W), .OPW(OPW)) bus ();

    alu_op_sequencer #(.WIDTH(W), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         fc;
        logic         er;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t           e;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        e.res = '0; e.rem = '0; e.fc = 1'b0; e.er = 1'b0; e.lat = 1;
        case (op)
            0: ;
            1: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.fc = s[W]; end
            2: begin e.res = a - b; e.fc = (a < b); end
            3: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0]; e.fc = |p[2*W-1:W]; e.lat = W;
            end
            4: begin
                if (b == '0) begin e.res = '1; e.rem = a; e.er = 1'b1; end
                else begin e.res = a / b; e.rem = a % b; e.lat = W; end
            end
            default: e.er = 1'b1;
        endcase
        return e;
    endfunction

    // Returns #1 after the accept edge E0.
    task automatic send(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.nr_coded = {op, b, a};
        bus.in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, compares against the scoreboard, optionally stalls, then handshakes.
    task automatic collect(input string tag, input int hold);
        int           lat;
        exp_t         e;
        logic [W-1:0] res0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_result"}, {28'd0, bus.result}, {28'd0, e.res});
            check({tag, "_remainder"}, {28'd0, bus.remainder}, {28'd0, e.rem});
            check({tag, "_flag_c"}, {31'd0, bus.flag_c}, {31'd0, e.fc});
            check({tag, "_err"}, {31'd0, bus.err}, {31'd0, e.er});
        end
        res0 = bus.result;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.nr_coded = {4'd1, 4'd1, 4'd1};
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "_hold_result"}, {28'd0, bus.result}, {28'd0, res0});
            check({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_post_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_post_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.nr_coded  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", {28'd0, bus.result}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        send(4'd1, 4'd7, 4'd5);  collect("add_7_5", 0);
        send(4'd1, 4'd9, 4'd8);  collect("add_9_8", 0);
        send(4'd2, 4'd3, 4'd5);  collect("sub_3_5", 0);
        send(4'd3, 4'd6, 4'd3);  collect("mul_6_3", 0);
        send(4'd3, 4'd3, 4'd5);  collect("mul_3_5", 0);
        send(4'd3, 4'd15, 4'd15); collect("mul_15_15", 0);
        send(4'd4, 4'd13, 4'd4); collect("div_13_4", 0);
        send(4'd4, 4'd15, 4'd1); collect("div_15_1", 0);
        send(4'd4, 4'd13, 4'd0); collect("div_by0", 0);
        send(4'd7, 4'd3, 4'd2);  collect("illegal_7", 0);
        send(4'd0, 4'd9, 4'd9);  collect("clr", 0);
        send(4'd2, 4'd9, 4'd4);  collect("stall_sub", 5);

        // The stall pulses must not have left a request behind.
        @(posedge clk);
        #1;
        check("no_queued_busy", {31'd0, bus.busy}, 32'd0);
        check("no_queued_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            logic [OPW-1:0] op;
            op = OPW'($urandom_range(0, 5));
            send(op, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            collect("rand", 0);
        end

        send(4'd1, 4'd7, 4'd5);  collect("pre_abort_add", 0);
        send(4'd3, 4'd7, 4'd7);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_result", {28'd0, bus.result}, 32'd0);
        check("abort_remainder", {28'd0, bus.remainder}, 32'd0);
        check("abort_flag_c", {31'd0, bus.flag_c}, 32'd0);
        check("abort_err", {31'd0, bus.err}, 32'd0);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        send(4'd1, 4'd2, 4'd2);  collect("post_abort_add", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
